mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 95 +++++++++
 tb/tb_mem_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and load/store, routing in-order responses back by owner.
// Optional MEM_ARB_ROUND_ROBIN_EN: round-robin on contention instead of data-first priority.
module mem_port_arbiter #(
    parameter int OUTST_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic [31:0] instr_rdata,
    output logic        instr_valid,
    output logic        instr_err,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    input  logic [3:0]  data_be,
    output logic        data_gnt,
    output logic [31:0] data_rdata,
    output logic        data_valid,
    output logic        data_error,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    input  logic        mem_err,
    output logic        resp_orphan
);
    localparam int PW = OUTST_DEPTH > 1 ? $clog2(OUTST_DEPTH) : 1;
    localparam int CW = $clog2(OUTST_DEPTH) + 1;
    logic          locked, lock_sel, sel, sel_req, full, push, pop, head, pri;
    logic          owner [OUTST_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0] count;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_gnt;
    assign pri = ~last_gnt;
`else
    assign pri = 1'b1;
`endif
    // sel: 0 = fetch, 1 = load/store; a stalled request keeps its registered owner
    assign sel         = locked ? lock_sel : (instr_req && data_req) ? pri : data_req;
    assign sel_req     = sel ? data_req : instr_req;
    assign full        = count == CW'(OUTST_DEPTH);
    assign mem_req     = reset_n && sel_req && !full;
    assign mem_wr      = sel && data_wr;
    assign mem_addr    = sel ? data_addr : instr_addr;
    assign mem_wdata   = sel ? data_wdata : '0;
    assign mem_be      = sel ? data_be : 4'hF;
    assign push        = mem_req && mem_gnt;
    assign instr_gnt   = push && !sel;
    assign data_gnt    = push && sel;
    assign pop         = mem_valid && count != '0;
    assign head        = owner[rd_ptr];
    assign instr_valid = reset_n && pop && !head;
    assign data_valid  = reset_n && pop && head;
    assign instr_err   = instr_valid && mem_err;
    assign data_error  = data_valid && mem_err;
    assign instr_rdata = mem_rdata;
    assign data_rdata  = mem_rdata;
    assign resp_orphan = reset_n && mem_valid && count == '0;
    assign wr_nxt      = wr_ptr == PW'(OUTST_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
    assign rd_nxt      = rd_ptr == PW'(OUTST_DEPTH - 1) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push) owner[wr_ptr] <= sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked   <= 1'b0;
            lock_sel <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_gnt <= 1'b0;
`endif
        end else begin
            locked   <= sel_req && !push && (mem_req || locked);
            lock_sel <= sel;
            wr_ptr   <= push ? wr_nxt : wr_ptr;
            rd_ptr   <= pop ? rd_nxt : rd_ptr;
            count    <= count + CW'(push) - CW'(pop);
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_gnt <= push ? sel : last_gnt;
`endif
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios then random traffic, checked against a queue-based owner model.
module tb_mem_port_arbiter;
    localparam int D = 2;
    logic clk = 1'b0, reset_n = 1'b0;
    logic instr_req = 0, data_req = 0, data_wr = 0, mem_gnt = 0, mem_valid = 0, mem_err = 0;
    logic [31:0] instr_addr = 0, data_addr = 0, data_wdata = 0, mem_rdata = 0;
    logic [3:0] data_be = 0;
    logic instr_gnt, instr_valid, instr_err, data_gnt, data_valid, data_error, mem_req, mem_wr, resp_orphan;
    logic [31:0] instr_rdata, data_rdata, mem_addr, mem_wdata;
    logic [3:0] mem_be;
    int passed = 0, total = 0;
    bit q[$];
    bit hold = 0, hold_who = 0, last = 0;
    logic [3:0] dseq = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.OUTST_DEPTH(D)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rdata(instr_rdata), .instr_valid(instr_valid), .instr_err(instr_err),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_be(data_be), .data_gnt(data_gnt), .data_rdata(data_rdata), .data_valid(data_valid),
        .data_error(data_error), .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
        .mem_valid(mem_valid), .mem_err(mem_err), .resp_orphan(resp_orphan)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference: a stalled request owns the port until granted or dropped; responses return in grant order.
    task automatic cyc();
        bit sel, sreq, mreq, push, pop, hd;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        bit pri = !last;
`else
        bit pri = 1;
`endif
        sel  = hold ? hold_who : (instr_req && data_req) ? pri : data_req;
        sreq = sel ? data_req : instr_req;
        mreq = sreq && q.size() < D;
        push = mreq && mem_gnt;
        pop  = mem_valid && q.size() > 0;
        hd   = pop ? q[0] : 1'b0;
        #4;
        chk("mem_req", mem_req, mreq);
        chk("instr_gnt", instr_gnt, push && !sel);
        chk("data_gnt", data_gnt, push && sel);
        chk("instr_valid", instr_valid, pop && !hd);
        chk("data_valid", data_valid, pop && hd);
        chk("instr_err", instr_err, pop && !hd && mem_err);
        chk("data_error", data_error, pop && hd && mem_err);
        chk("resp_orphan", resp_orphan, mem_valid && q.size() == 0);
        if (mreq) begin
            chk("mem_addr", mem_addr, sel ? data_addr : instr_addr);
            chk("mem_wr", mem_wr, sel && data_wr);
            chk("mem_be", mem_be, sel ? data_be : 4'hF);
            chk("mem_wdata", mem_wdata, sel ? data_wdata : 32'h0);
        end
        if (pop) chk("rdata", hd ? data_rdata : instr_rdata, mem_rdata);
        dseq = {dseq[2:0], data_gnt};
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (push) begin
            q.push_back(sel);
            last = sel;
        end
        hold = sreq && !push && (mreq || hold);
        hold_who = sel;
        #1;
    endtask

    task automatic do_reset();
        reset_n = 0;
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_gnt", {instr_gnt, data_gnt}, 0);
        chk("rst_valid", {instr_valid, data_valid}, 0);
        chk("rst_err", {instr_err, data_error}, 0);
        chk("rst_orphan", resp_orphan, 0);
        q.delete();
        hold = 0;
        last = 0;
        @(posedge clk);
        #1;
        reset_n = 1;
    endtask

    task automatic set(input bit ir, input logic [31:0] ia, input bit dr, input bit g, input bit v, input logic [31:0] rd);
        instr_req = ir; instr_addr = ia; data_req = dr; mem_gnt = g; mem_valid = v; mem_rdata = rd;
    endtask

    task automatic drain();
        set(0, 0, 0, 0, 1, 32'hD0D0);
        while (q.size() > 0) cyc();
        mem_valid = 0;
    endtask

    initial begin
        instr_req = 1; data_req = 1; mem_valid = 1;
        @(posedge clk);
        #1;
        do_reset();
        set(0, 0, 0, 0, 0, 0);
        cyc();
        // single fetch
        set(1, 32'h100, 0, 1, 0, 0); cyc();
        set(0, 0, 0, 0, 1, 32'h13); cyc();
        // contention with responses flowing
        data_addr = 32'h400; data_wr = 1; data_wdata = 32'hCAFE; data_be = 4'h3;
        set(1, 32'h104, 1, 1, 0, 0); cyc();
        mem_valid = 1; mem_rdata = 32'h55; cyc(); cyc(); cyc();
`ifdef MEM_ARB_ROUND_ROBIN_EN
        chk("contention_seq", dseq, 4'b1010);
`else
        chk("contention_seq", dseq, 4'b1111);
`endif
        drain();
        // lock against late data request
        data_wr = 0;
        set(1, 32'h200, 0, 0, 0, 0); cyc();
        data_req = 1; cyc(); cyc();
        mem_gnt = 1; cyc();
        instr_req = 0; cyc();
        drain();
        // full FIFO backpressure
        set(1, 32'h300, 0, 1, 0, 0); cyc(); cyc(); cyc();
        mem_valid = 1; mem_rdata = 32'hAA; mem_err = 1; cyc();
        mem_valid = 0; mem_err = 0; cyc();
        drain();
        // reset with two outstanding, then stray response
        set(1, 32'h500, 1, 1, 0, 0); cyc(); cyc();
        do_reset();
        set(0, 0, 0, 0, 1, 32'hBEEF); cyc();
        mem_valid = 0; cyc();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset();
            instr_req = 1'($urandom_range(0, 3) != 0);
            data_req = 1'($urandom_range(0, 2) != 0);
            instr_addr = $urandom; data_addr = $urandom; data_wdata = $urandom;
            data_wr = 1'($urandom); data_be = 4'($urandom);
            mem_gnt = 1'($urandom_range(0, 2) != 0);
            mem_valid = 1'($urandom_range(0, 2) == 0);
            mem_err = 1'($urandom_range(0, 4) == 0);
            mem_rdata = $urandom;
            cyc();
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
